port_rd_frontend: RTL

// - Per-port egress side of the switch: mirror of the write frontend. Selects one of 8 priority

---
 rtl/hydra_pkg.sv | 42 ++++
 rtl/rd_prio_arbiter.sv | 70 +++++++
 rtl/port_rd_frontend.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hydra_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hydra_pkg
// Purpose : Shared definitions for the egress read frontend.
//           - control-word field positions (dest / prio / length)
//           - default priority-queue count and WRR credit width
//           - read-side FSM state encoding
//           - initial WRR credit for a priority (p+1)
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package hydra_pkg;

  localparam int DEF_PRIO_NUM  = 8;
  localparam int PRIO_W        = 3;
  localparam int CREDIT_W      = 4;

  localparam int CTRL_DEST_LSB = 0;
  localparam int CTRL_DEST_MSB = 3;
  localparam int CTRL_PRIO_LSB = 4;
  localparam int CTRL_PRIO_MSB = 6;
  localparam int CTRL_LEN_LSB  = 7;
  localparam int CTRL_LEN_MSB  = 15;

  localparam int DEST_W = CTRL_DEST_MSB - CTRL_DEST_LSB + 1;
  localparam int LEN_W  = CTRL_LEN_MSB - CTRL_LEN_LSB + 1;

  typedef enum logic [2:0] {
    RD_IDLE   = 3'd0,
    RD_REQ    = 3'd1,
    RD_WAIT   = 3'd2,
    RD_STREAM = 3'd3,
    RD_EOP    = 3'd4
  } rd_state_e;

  // Weight of a priority queue: higher priorities get more grants per round.
  function automatic logic [CREDIT_W-1:0] init_credit(input int p);
    return CREDIT_W'(p + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rd_prio_arbiter
// Purpose : Picks which priority queue to read next.
//           Strict mode : highest non-empty priority.
//           WRR mode    : highest non-empty priority that still has credit;
//                         when none has credit, all credits reload to p+1 as
//                         the pick is latched. Credits drop on each grant.
// Ports   : clk, rst          clock / async active-high reset
//           wrr_enable        1 = weighted round robin, 0 = strict
//           queue_not_empty   per-priority occupancy
//           pick_load         pick is being latched this cycle
//           grant             request for grant_prio was accepted
//           grant_prio        priority that was granted
//           pick              current arbitration result
// Rev     : 1.0  initial release
// ============================================================================
module rd_prio_arbiter
  import hydra_pkg::*;
#(
  parameter int PRIO_NUM = DEF_PRIO_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrr_enable,
  input  logic [PRIO_NUM-1:0] queue_not_empty,
  input  logic                pick_load,
  input  logic                grant,
  input  logic [PRIO_W-1:0]   grant_prio,
  output logic [PRIO_W-1:0]   pick
);

  logic [PRIO_NUM-1:0] has_credit;
  logic [PRIO_NUM-1:0] candidates;
  logic                reload;

  generate
    for (genvar p = 0; p < PRIO_NUM; p++) begin : g_credit
      logic [CREDIT_W-1:0] credit;

      assign has_credit[p] = queue_not_empty[p] && (credit != '0);

      // Credits are only touched in WRR mode, so toggling the mode holds them.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          credit <= init_credit(p);
        end else if (pick_load && reload) begin
          credit <= init_credit(p);
        end else if (grant && wrr_enable && (grant_prio == PRIO_W'(p)) && (credit != '0)) begin
          credit <= credit - CREDIT_W'(1);
        end
      end
    end
  endgenerate

  always_comb begin
    reload     = wrr_enable && (has_credit == '0);
    // After a reload every non-empty queue has credit again, so the plain
    // occupancy vector is the correct candidate set in that cycle.
    candidates = (wrr_enable && !reload) ? has_credit : queue_not_empty;
    pick       = '0;
    for (int p = 0; p < PRIO_NUM; p++) begin
      if (candidates[p]) begin
        pick = PRIO_W'(p);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_rd_frontend.sv
`default_nettype none
// ============================================================================
// Module  : port_rd_frontend
// Purpose : Egress side of one switch port. Arbitrates among the priority
//           queues, requests the head packet from the SRAM side and replays
//           the returned word stream as rd_sop / rd_vld+rd_data / rd_eop,
//           flagging length and destination mismatches with rd_eop.
// Ports   : clk, rst             clock / async active-high reset
//           ready                downstream can take a new packet (IDLE only)
//           wrr_enable           1 = WRR arbitration, 0 = strict priority
//           queue_not_empty      per-priority occupancy
//           pkt_req/pkt_req_prio request to SRAM side and its priority
//           pkt_ack              SRAM side accepted the request
//           xfer_data_vld/xfer_data/xfer_end_of_packet  incoming word stream
//           rd_sop/rd_vld/rd_data/rd_eop                 outgoing stream
//           len_err/dest_err     error pulses aligned with rd_eop
// Rev     : 1.0  initial release
// ============================================================================
module port_rd_frontend
  import hydra_pkg::*;
#(
  parameter int PORT_IDX   = 0,
  parameter int DATA_WIDTH = 16,
  parameter int PRIO_NUM   = DEF_PRIO_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  input  logic                  wrr_enable,
  input  logic [PRIO_NUM-1:0]   queue_not_empty,
  output logic                  pkt_req,
  output logic [PRIO_W-1:0]     pkt_req_prio,
  input  logic                  pkt_ack,
  input  logic                  xfer_data_vld,
  input  logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  xfer_end_of_packet,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  len_err,
  output logic                  dest_err
);

  rd_state_e             state;
  rd_state_e             state_nxt;
  logic                  pick_load;
  logic                  grant;
  logic                  accept;
  logic                  first_word;
  logic [PRIO_W-1:0]     arb_pick;

  logic                  s1_vld;
  logic                  s1_eop;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s2_eop;

  logic [DEST_W-1:0]     ctrl_dest;
  logic [LEN_W-1:0]      ctrl_len;
  logic [LEN_W-1:0]      pay_cnt;

  rd_prio_arbiter #(
    .PRIO_NUM (PRIO_NUM)
  ) u_arb (
    .clk             (clk),
    .rst             (rst),
    .wrr_enable      (wrr_enable),
    .queue_not_empty (queue_not_empty),
    .pick_load       (pick_load),
    .grant           (grant),
    .grant_prio      (pkt_req_prio),
    .pick            (arb_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pkt_req    = 1'b0;
    pick_load  = 1'b0;
    grant      = 1'b0;
    accept     = 1'b0;
    first_word = 1'b0;
    case (state)
      RD_IDLE: begin
        if (ready && (|queue_not_empty)) begin
          pick_load = 1'b1;
          state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        pkt_req = 1'b1;
        if (pkt_ack) begin
          grant     = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (xfer_data_vld) begin
          accept     = 1'b1;
          first_word = 1'b1;
          state_nxt  = xfer_end_of_packet ? RD_EOP : RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (xfer_data_vld) begin
          accept = 1'b1;
          if (xfer_end_of_packet) begin
            state_nxt = RD_EOP;
          end
        end
      end
      RD_EOP: begin
        // Leave once the last word sits in the output stage; rd_eop follows
        // in the same cycle the FSM is back in IDLE.
        if (rd_vld && s2_eop) begin
          state_nxt = RD_IDLE;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_req_prio <= '0;
    end else if (pick_load) begin
      pkt_req_prio <= arb_pick;
    end
  end

  // Two-stage word pipe: stage 1 = s1_*, stage 2 = rd_vld/rd_data/s2_eop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_data  <= '0;
      rd_vld   <= 1'b0;
      rd_data  <= '0;
      s2_eop   <= 1'b0;
      rd_sop   <= 1'b0;
      rd_eop   <= 1'b0;
      len_err  <= 1'b0;
      dest_err <= 1'b0;
    end else begin
      s1_vld   <= accept;
      s1_eop   <= accept && xfer_end_of_packet;
      if (accept) begin
        s1_data <= xfer_data;
      end
      rd_vld   <= s1_vld;
      rd_data  <= s1_vld ? s1_data : '0;
      s2_eop   <= s1_vld && s1_eop;
      rd_sop   <= first_word;
      rd_eop   <= rd_vld && s2_eop;
      len_err  <= rd_vld && s2_eop && (pay_cnt != ctrl_len);
      dest_err <= rd_vld && s2_eop && (ctrl_dest != DEST_W'(PORT_IDX));
    end
  end

  // Control-word capture and saturating payload counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_dest <= '0;
      ctrl_len  <= '0;
      pay_cnt   <= '0;
    end else if (first_word) begin
      ctrl_dest <= xfer_data[CTRL_DEST_MSB:CTRL_DEST_LSB];
      ctrl_len  <= xfer_data[CTRL_LEN_MSB:CTRL_LEN_LSB];
      pay_cnt   <= '0;
    end else if (accept && (pay_cnt != '1)) begin
      pay_cnt <= pay_cnt + LEN_W'(1);
    end
  end

endmodule
`default_nettype wire
